// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one 8N1 UART transmitter.
// Holds the granted byte on tx_data until the frame completes.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 tx_en_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_rdy_i,
  output logic                 busy_o,
  output logic [ID_W-1:0]      grant_id_o,
  output logic                 frame_done_o,
  output logic                 tx_err_o
);

  localparam int TW = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            tx_en_q, tx_en_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [2*NUM_REQ-1:0] rot;
  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic                 accept;
  logic [7:0]           win_byte;
  logic [ID_W-1:0]      rr_nxt;

  // Pick the first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    rot       = {req_valid_i, req_valid_i} >> rr_ptr_q;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && rot[k]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign accept = !rst && (state_q == IDLE)
               && tx_rdy_i && win_found;

  assign req_ready_o = accept ? (NUM_REQ'(1) << win_id) : '0;

  assign win_byte = 8'(req_data_i >> {win_id, 3'b000});

  assign rr_nxt = (grant_q == ID_LAST) ? '0
                : grant_q + ID_W'(1);

  // Next-state and registered-output logic for the frame FSM.
  always_comb begin
    state_d   = state_q;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_d     = tmo_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tx_data_d = win_byte;
          grant_d   = win_id;
          tx_en_d   = 1'b1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_rdy_i) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          rr_ptr_d = rr_nxt;
          state_d  = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_rdy_i) begin
          done_d   = 1'b1;
          rr_ptr_d = rr_nxt;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_en_o      = tx_en_q;
  assign tx_data_o    = tx_data_q;
  assign grant_id_o   = grant_q;
  assign frame_done_o = done_q;
  assign tx_err_o     = err_q;
  assign busy_o       = (state_q != IDLE);

  a_ready_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(req_ready_o)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random and directed checks of uart_tx_arbiter
// against a frame-level reference model and a simple 8N1 transmitter.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int BT  = 8;
  localparam int CPB = 2;

  localparam int M_HOLD  = 0;
  localparam int M_RAND  = 1;
  localparam int M_FIXED = 2;
  localparam int M_NONE  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            tx_en;
  logic [7:0]      tx_data;
  logic            tx_rdy;
  logic            busy;
  logic [IW-1:0]   grant_id;
  logic            frame_done;
  logic            tx_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .ID_W(IW),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid),
    .req_data_i(req_data),
    .req_ready_o(req_ready),
    .tx_en_o(tx_en),
    .tx_data_o(tx_data),
    .tx_rdy_i(tx_rdy),
    .busy_o(busy),
    .grant_id_o(grant_id),
    .frame_done_o(frame_done),
    .tx_err_o(tx_err)
  );

  // Behavioural 8N1 transmitter: rdy drops 2 cycles after tx_en,
  // each bit is taken live from tx_data and logged per frame.
  logic       xm_dead;
  int         xm_st;
  int         xm_cnt;
  logic [9:0] xm_frm;
  logic [9:0] xm_log [256];
  int         xm_wr;

  function automatic logic fbit(int b, logic [7:0] d);
    logic [7:0] t;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    t = d >> (b - 1);
    return t[0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      xm_st  <= 0;
      tx_rdy <= 1'b1;
      xm_cnt <= 0;
      xm_wr  <= 0;
    end else begin
      case (xm_st)
        0: if (tx_en && !xm_dead) xm_st <= 1;
        1: begin
          tx_rdy <= 1'b0;
          xm_cnt <= 0;
          xm_st  <= 2;
        end
        default: begin
          if (xm_cnt % CPB == 0)
            xm_frm[xm_cnt/CPB] <= fbit(xm_cnt / CPB, tx_data);
          if (xm_cnt == 10 * CPB - 1) begin
            xm_log[xm_wr % 256] <= xm_frm;
            xm_wr  <= xm_wr + 1;
            tx_rdy <= 1'b1;
            xm_st  <= 0;
          end
          xm_cnt <= xm_cnt + 1;
        end
      endcase
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state (frame-level view).
  int         cyc;
  int         mode;
  logic       pv [N];
  logic [7:0] pd [N];
  bit         m_inflight;
  bit         m_fell;
  int         m_ptr;
  int         m_id;
  logic [7:0] m_byte;
  int         m_launch;
  int         m_done_at;
  int         m_err_at;
  int         xm_rd;
  int         n_acc;
  int         n_done;
  int         n_err;
  int         acc [64];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      case (mode)
        M_RAND: begin
          if (!pv[i] && $urandom_range(0, 3) == 0) begin
            pv[i] = 1'b1;
            pd[i] = 8'($urandom);
          end
        end
        M_FIXED: begin
          pv[i] = 1'b1;
          pd[i] = 8'((i + 1) * 17);
        end
        M_NONE: pv[i] = 1'b0;
        default: ;
      endcase
      req_valid[i]       = pv[i];
      req_data[8*i +: 8] = pd[i];
    end
  endtask

  task automatic step();
    int w;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    cyc++;
    chk("tx_en", tx_en, cyc == m_launch);
    chk("busy", busy, m_inflight);
    chk("frame_done", frame_done, cyc == m_done_at);
    chk("tx_err", tx_err, cyc == m_err_at);
    chk("grant_id", grant_id, m_id);
    chk("tx_data", tx_data, m_byte);
    if (cyc == m_done_at) begin
      if (xm_rd >= xm_wr) begin
        chk("frame_avail", 0, 1);
      end else begin
        chk("frame_bits", xm_log[xm_rd % 256], {1'b1, m_byte, 1'b0});
        xm_rd++;
      end
    end
    drive();
    #1;
    w = -1;
    if (!m_inflight && tx_rdy) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && pv[i]) w = i;
      end
    end
    exp_rdy = (w < 0) ? '0 : N'(1) << w;
    chk("req_ready", req_ready, exp_rdy);
    if (w >= 0) begin
      m_inflight = 1;
      m_fell     = 0;
      m_id       = w;
      m_byte     = pd[w];
      m_launch   = cyc + 1;
      pv[w]      = 1'b0;
      if (n_acc < 64) acc[n_acc] = w;
      n_acc++;
    end else if (m_inflight && cyc > m_launch) begin
      if (!m_fell) begin
        if (!tx_rdy) begin
          m_fell = 1;
        end else if (cyc == m_launch + BT) begin
          m_err_at   = cyc + 1;
          m_inflight = 0;
          m_ptr      = (m_id + 1) % N;
          n_err++;
        end
      end else if (tx_rdy) begin
        m_done_at  = cyc + 1;
        m_inflight = 0;
        m_ptr      = (m_id + 1) % N;
        n_done++;
      end
    end
  endtask

  task automatic do_reset(int n);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_ready_now", req_ready, 0);
    repeat (n) begin
      @(negedge clk);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", tx_err, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_data", tx_data, 0);
    end
    rst = 1'b0;
    req_valid = '0;
    m_inflight = 0;
    m_fell = 0;
    m_ptr = 0;
    m_id = 0;
    m_byte = 8'h00;
    m_launch = -100;
    m_done_at = -100;
    m_err_at = -100;
    xm_rd = 0;
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
  endtask

  task automatic clr_counts();
    n_acc = 0;
    n_done = 0;
    n_err = 0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    xm_dead = 1'b0;
    mode = M_HOLD;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0;
      pd[i] = 8'h00;
    end
    do_reset(3);

    // Single byte from requester 0.
    clr_counts();
    pv[0] = 1'b1;
    pd[0] = 8'hA5;
    mode = M_HOLD;
    repeat (40) step();
    chk("t1_accepts", n_acc, 1);
    chk("t1_done", n_done, 1);
    chk("t1_line", xm_log[0], 10'h34A);
    chk("t1_gid", acc[0], 0);

    // All four held valid: strict rotation.
    do_reset(2);
    clr_counts();
    mode = M_FIXED;
    repeat (140) step();
    chk("t2_count", n_acc >= 5, 1);
    chk("t2_o0", acc[0], 0);
    chk("t2_o1", acc[1], 1);
    chk("t2_o2", acc[2], 2);
    chk("t2_o3", acc[3], 3);
    chk("t2_o4", acc[4], 0);

    // Pointer at 2 after requester 1, then 1011 -> 3,0,1.
    do_reset(2);
    mode = M_HOLD;
    pv[1] = 1'b1;
    pd[1] = 8'($urandom);
    repeat (40) step();
    clr_counts();
    pv[0] = 1'b1;
    pv[1] = 1'b1;
    pv[3] = 1'b1;
    pd[0] = 8'($urandom);
    pd[1] = 8'($urandom);
    pd[3] = 8'($urandom);
    repeat (90) step();
    chk("t3_count", n_acc, 3);
    chk("t3_o0", acc[0], 3);
    chk("t3_o1", acc[1], 0);
    chk("t3_o2", acc[2], 1);

    // Random traffic.
    clr_counts();
    mode = M_RAND;
    repeat (2000) step();
    chk("rand_done", n_done > 20, 1);

    // Dead transmitter: timeouts, then recovery.
    mode = M_NONE;
    repeat (40) step();
    xm_dead = 1'b1;
    clr_counts();
    mode = M_RAND;
    repeat (200) step();
    chk("t5_err", n_err > 3, 1);
    chk("t5_nodone", n_done, 0);
    mode = M_NONE;
    repeat (40) step();
    xm_dead = 1'b0;
    mode = M_RAND;
    repeat (300) step();

    // Reset in the middle of a data bit.
    guard = 0;
    while (tx_rdy && guard < 200) begin
      step();
      guard++;
    end
    chk("t6_started", tx_rdy, 0);
    repeat (5) step();
    do_reset(3);
    clr_counts();
    mode = M_HOLD;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b1;
      pd[i] = 8'($urandom);
    end
    repeat (30) step();
    chk("t6_first", acc[0], 0);
    chk("t6_done", n_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
